// File: rtl/sprite_ctrl.sv
// sprite_ctrl: double-buffered sprite position table plus queued texture writes.
// Optional statistics counters are enabled with SPRITE_CTRL_STATS_EN.
module sprite_ctrl #(
    parameter int SIZE        = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 32,
    parameter int COLOR_WIDTH = 12,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic                              cfg_sel,
    input  logic [INDEX_WIDTH-1:0]            cfg_addr,
    input  logic [DATA_WIDTH-1:0]             cfg_wdata,
    input  logic                              vsync,
    input  logic                              pix_active,
    input  logic [INDEX_WIDTH-1:0]            pix_index,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]   i,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]   j,
    output logic [INDEX_WIDTH-1:0]            mem_addr,
    output logic                              mem_we,
    output logic [COLOR_WIDTH-1:0]            mem_wdata,
`ifdef SPRITE_CTRL_STATS_EN
    output logic [31:0]                       stat_frames,
    output logic [31:0]                       stat_stalls,
`endif
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = INDEX_WIDTH + COLOR_WIDTH;

    typedef enum logic [1:0] {
        S_DISPLAY,
        S_DRAIN,
        S_IDLE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SIZE-1:0][DATA_WIDTH-1:0] r_sh_i;
    logic [SIZE-1:0][DATA_WIDTH-1:0] r_sh_j;
    logic [SIZE-1:0][DATA_WIDTH-1:0] r_act_i;
    logic [SIZE-1:0][DATA_WIDTH-1:0] r_act_j;
    logic                            r_commit_pend;

    logic [EW-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic [LW-1:0] w_count_nxt;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_pos_we;
    logic [INDEX_WIDTH-2:0] w_sprite;
    logic [EW-1:0]          w_head;

    assign w_full    = (r_count == LW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign cfg_ready = !rst && (cfg_sel || !w_full);
    assign w_push    = cfg_valid && cfg_ready && !cfg_sel;
    assign w_pos_we  = cfg_valid && cfg_ready && cfg_sel;
    assign w_sprite  = cfg_addr[INDEX_WIDTH-1:1];
    assign w_head    = r_fifo[r_rd_ptr];

    // Pixel path wins whenever it is active; no write can slip in that cycle.
    assign w_pop = (r_state == S_DRAIN) && !pix_active && !w_empty;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + LW'(1);
            2'b01:   w_count_nxt = r_count - LW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Shadow table: sprite numbers >= SIZE match no entry and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_i <= '1;
            r_sh_j <= '1;
        end else begin
            for (int k = 0; k < SIZE; k++) begin
                if (w_pos_we && (w_sprite == (INDEX_WIDTH-1)'(k))) begin
                    if (cfg_addr[0]) begin
                        r_sh_j[k] <= cfg_wdata;
                    end else begin
                        r_sh_i[k] <= cfg_wdata;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_pend <= 1'b0;
            r_act_i       <= '1;
            r_act_j       <= '1;
        end else begin
            r_commit_pend <= vsync;
            if (r_commit_pend) begin
                r_act_i <= r_sh_i;
                r_act_j <= r_sh_j;
            end
        end
    end

    assign i = r_act_i;
    assign j = r_act_j;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {cfg_addr, cfg_wdata[COLOR_WIDTH-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    assign fifo_level = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_DISPLAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_we      = 1'b0;
        mem_addr    = pix_index;
        mem_wdata   = '0;
        unique case (r_state)
            S_DISPLAY: begin
                if (!pix_active) begin
                    w_state_nxt = w_empty ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pix_active) begin
                    w_state_nxt = S_DISPLAY;
                end else if (w_count_nxt == '0) begin
                    w_state_nxt = S_IDLE;
                end
                if (w_pop) begin
                    mem_we    = 1'b1;
                    mem_addr  = w_head[EW-1:COLOR_WIDTH];
                    mem_wdata = w_head[COLOR_WIDTH-1:0];
                end
            end
            S_IDLE: begin
                if (pix_active) begin
                    w_state_nxt = S_DISPLAY;
                end else if (!w_empty) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: w_state_nxt = S_DISPLAY;
        endcase
    end

`ifdef SPRITE_CTRL_STATS_EN
    logic [31:0] r_frames;
    logic [31:0] r_stalls;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frames <= '0;
            r_stalls <= '0;
        end else begin
            if (r_commit_pend) begin
                r_frames <= r_frames + 32'd1;
            end
            if (cfg_valid && !cfg_ready && (r_stalls != '1)) begin
                r_stalls <= r_stalls + 32'd1;
            end
        end
    end

    assign stat_frames = r_frames;
    assign stat_stalls = r_stalls;
`endif

endmodule

// File: tb/tb_sprite_ctrl.sv
// tb_sprite_ctrl: directed tests for sprite_ctrl.
// Covers commit timing, texture queue drain/preemption and reset.
module tb_sprite_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_sel;
    logic [31:0]       cfg_addr;
    logic [31:0]       cfg_wdata;
    logic              vsync;
    logic              pix_active;
    logic [31:0]       pix_index;
    logic [9:0][31:0]  w_i;
    logic [9:0][31:0]  w_j;
    logic [31:0]       mem_addr;
    logic              mem_we;
    logic [11:0]       mem_wdata;
    logic [2:0]        fifo_level;
`ifdef SPRITE_CTRL_STATS_EN
    logic [31:0]       stat_frames;
    logic [31:0]       stat_stalls;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] PARK = 32'hFFFF_FFFF;

    sprite_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_sel    (cfg_sel),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .vsync      (vsync),
        .pix_active (pix_active),
        .pix_index  (pix_index),
        .i          (w_i),
        .j          (w_j),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
`ifdef SPRITE_CTRL_STATS_EN
        .stat_frames(stat_frames),
        .stat_stalls(stat_stalls),
`endif
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0 && pix_active === 1'b1) begin
            checks++;
            if (mem_we !== 1'b0) begin
                errors++;
                $display("FAIL we_during_active: mem_we=%b required 0", mem_we);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pos_write(input int spr, input logic fld,
                             input logic [31:0] d);
        cfg_valid = 1'b1;
        cfg_sel   = 1'b1;
        cfg_addr  = {spr[30:0], fld};
        cfg_wdata = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic tex_write(input logic [31:0] a, input logic [31:0] d);
        cfg_valid = 1'b1;
        cfg_sel   = 1'b0;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cfg_sel = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: cfg_ready=%b required 0", cfg_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        cfg_sel = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (w_i[k] !== PARK || w_j[k] !== PARK) begin
                errors++;
                $display("FAIL rst_pos[%0d]: i=%h j=%h required %h",
                         k, w_i[k], w_j[k], PARK);
            end
        end
        checks++;
        if (mem_we !== 1'b0 || fifo_level !== 3'd0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ctl: we=%b lvl=%0d rdy=%b required 0 0 1",
                     mem_we, fifo_level, cfg_ready);
        end
`ifdef SPRITE_CTRL_STATS_EN
        checks++;
        if (stat_frames !== 32'd0 || stat_stalls !== 32'd0) begin
            errors++;
            $display("FAIL rst_stats: frames=%0d stalls=%0d required 0 0",
                     stat_frames, stat_stalls);
        end
`endif
    endtask

    task automatic test_commit;
        pos_write(3, 1'b0, 32'd100);
        pos_write(3, 1'b1, 32'd40);
        tick();
        checks++;
        if (w_i[3] !== PARK) begin
            errors++;
            $display("FAIL no_commit: i3=%h required %h", w_i[3], PARK);
        end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        checks++;
        if (w_i[3] !== PARK) begin
            errors++;
            $display("FAIL commit_early: i3=%h required %h", w_i[3], PARK);
        end
        tick();
        checks++;
        if (w_i[3] !== 32'd100 || w_j[3] !== 32'd40) begin
            errors++;
            $display("FAIL commit: i3=%0d j3=%0d required 100 40",
                     w_i[3], w_j[3]);
        end
        checks++;
        if (w_i[2] !== PARK || w_j[4] !== PARK) begin
            errors++;
            $display("FAIL commit_other: i2=%h j4=%h required %h",
                     w_i[2], w_j[4], PARK);
        end
    endtask

    task automatic test_write_in_vsync;
        cfg_valid = 1'b1;
        cfg_sel   = 1'b1;
        cfg_addr  = {31'd3, 1'b0};
        cfg_wdata = 32'd200;
        vsync     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        vsync     = 1'b0;
        tick();
        checks++;
        if (w_i[3] !== 32'd200 || w_j[3] !== 32'd40) begin
            errors++;
            $display("FAIL vsync_write: i3=%0d j3=%0d required 200 40",
                     w_i[3], w_j[3]);
        end
        pos_write(12, 1'b0, 32'd5);
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        tick();
        tick();
        checks++;
        if (w_i[3] !== 32'd200 || w_i[9] !== PARK) begin
            errors++;
            $display("FAIL double_vsync: i3=%0d i9=%h required 200 %h",
                     w_i[3], w_i[9], PARK);
        end
    endtask

    task automatic test_fifo_drain;
        pix_active = 1'b1;
        pix_index  = 32'h55;
        tick();
        for (int a = 0; a < 4; a++) begin
            cfg_sel = 1'b0;
            #1;
            checks++;
            if (cfg_ready !== 1'b1 || mem_addr !== 32'h55) begin
                errors++;
                $display("FAIL fill_ready[%0d]: rdy=%b addr=%h required 1 55",
                         a, cfg_ready, mem_addr);
            end
            tex_write(a, 32'hABC);
        end
        cfg_valid = 1'b1;
        cfg_addr  = 32'd9;
        tick();
        tick();
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (fifo_level !== 3'd4 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: lvl=%0d rdy=%b required 4 0",
                     fifo_level, cfg_ready);
        end
        pix_active = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL display_we: mem_we=%b required 0", mem_we);
        end
        tick();
        for (int a = 0; a < 4; a++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== 12'hABC) begin
                errors++;
                $display("FAIL drain[%0d]: we=%b addr=%0d data=%h required 1 %0d ABC",
                         a, mem_we, mem_addr, mem_wdata, a);
            end
            tick();
        end
        checks++;
        if (mem_we !== 1'b0 || fifo_level !== 3'd0 || mem_addr !== 32'h55) begin
            errors++;
            $display("FAIL drain_end: we=%b lvl=%0d addr=%h required 0 0 55",
                     mem_we, fifo_level, mem_addr);
        end
    endtask

    task automatic test_preempt;
        pix_active = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            tex_write(a, 32'h100 + a);
        end
        pix_active = 1'b0;
        tick();
        for (int a = 0; a < 2; a++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== a) begin
                errors++;
                $display("FAIL pre_drain[%0d]: we=%b addr=%0d required 1 %0d",
                         a, mem_we, mem_addr, a);
            end
            tick();
        end
        pix_active = 1'b1;
        pix_index  = 32'h77;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h77 || fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL preempt: we=%b addr=%h lvl=%0d required 0 77 2",
                     mem_we, mem_addr, fifo_level);
        end
        tick();
        tick();
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL preempt_hold: lvl=%0d required 2", fifo_level);
        end
        pix_active = 1'b0;
        tick();
        for (int a = 2; a < 4; a++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== 12'h100 + a) begin
                errors++;
                $display("FAIL resume[%0d]: we=%b addr=%0d data=%h required 1 %0d %h",
                         a, mem_we, mem_addr, mem_wdata, a, 12'h100 + a);
            end
            tick();
        end
        checks++;
        if (mem_we !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL resume_end: we=%b lvl=%0d required 0 0",
                     mem_we, fifo_level);
        end
    endtask

    task automatic test_reset_mid;
        pix_active = 1'b1;
        tick();
        for (int a = 0; a < 3; a++) begin
            tex_write(32'h40 + a, 32'h5);
        end
        pos_write(5, 1'b0, 32'd7);
        checks++;
        if (fifo_level !== 3'd3) begin
            errors++;
            $display("FAIL pre_rst_lvl: lvl=%0d required 3", fifo_level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pix_active = 1'b0;
        #1;
        checks++;
        if (fifo_level !== 3'd0 || w_i[3] !== PARK || w_j[3] !== PARK) begin
            errors++;
            $display("FAIL mid_rst: lvl=%0d i3=%h j3=%h required 0 %h %h",
                     fifo_level, w_i[3], w_j[3], PARK, PARK);
        end
`ifdef SPRITE_CTRL_STATS_EN
        checks++;
        if (stat_frames !== 32'd0 || stat_stalls !== 32'd0) begin
            errors++;
            $display("FAIL mid_rst_stats: frames=%0d stalls=%0d required 0 0",
                     stat_frames, stat_stalls);
        end
`endif
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (mem_we !== 1'b0) begin
                errors++;
                $display("FAIL blank_after_rst[%0d]: mem_we=%b required 0",
                         c, mem_we);
            end
            tick();
        end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        checks++;
        if (w_i[5] !== PARK) begin
            errors++;
            $display("FAIL shadow_discard: i5=%h required %h", w_i[5], PARK);
        end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_sel    = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        vsync      = 1'b0;
        pix_active = 1'b0;
        pix_index  = 32'h55;
        test_reset();
        test_commit();
        test_write_in_vsync();
        test_fifo_drain();
        test_preempt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
